sd_spi_cmd_framer: RTL and testbench
====================================

// Module: sd_spi_cmd_framer
// PURPOSE
//  SD-card SPI-mode command framer: consumes the byte stream recovered by the SPI slave shifter (one byte per
//  rx_vld_i pulse), locks onto 48-bit SD command frames, checks framing bits and emits index/argument/CRC to
//  the command-handler state machine through a valid/ready handshake. Sits between shifter and SD handler.
// PARAMETERS
//  ERR_CNT_W  8      width of saturating frame-error counter
//  FILL_BYTE  8'hFF  idle/fill byte silently discarded while hunting for a start byte
// PORTS
//  SCLK             in   1          SPI serial clock; all state updates on posedge
//  rstn             in   1          reset, asynchronous, active-low
//  nss_i            in   1          chip select; high = synchronous abort of any frame in progress
//  rx_byte_i        in   8          received byte, MSB = first bit on wire
//  rx_vld_i         in   1          one-SCLK pulse, rx_byte_i valid
//  cmd_rdy_i        in   1          handler accepts current command
//  clr_i            in   1          clears ovr_o and frame_err_cnt_o
//  cmd_vld_o        out  1          command frame available
//  cmd_idx_o        out  6          frame bits [45:40]
//  cmd_arg_o        out  32         frame bits [39:8]
//  cmd_crc_o        out  7          frame bits [7:1] as received
//  crc_err_o        out  1          received CRC7 != computed CRC7 (qualifies cmd_vld_o)
//  busy_o           out  1          state != IDLE
//  ovr_o            out  1          sticky: byte arrived while in HOLD
//  frame_err_cnt_o  out  ERR_CNT_W  saturating count of frames with end bit 0
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, byte count 0, shift register 0.
//  FSM IDLE->COLLECT->HOLD->IDLE.
//   IDLE: rx_vld_i && rx_byte_i[7:6]==2'b01 -> store byte, cnt=1, COLLECT; FILL_BYTE or other bytes ignored.
//   COLLECT: each rx_vld_i shifts byte into 48-bit reg, cnt++. On 6th byte: bit0==1 -> HOLD, cmd_vld_o=1
//    from next posedge (1 SCLK latency after last byte sampled); bit0==0 -> frame dropped, IDLE, counter++.
//   HOLD: outputs stable until posedge with cmd_vld_o&&cmd_rdy_i; next cycle cmd_vld_o=0, state IDLE.
//    Any rx_vld_i in HOLD (including the handshake cycle) dropped and sets ovr_o.
//  nss_i==1 (any state): next posedge state IDLE, cnt=0, cmd_vld_o=0 (pending command discarded);
//   ovr_o and counter retained. rx_vld_i ignored while nss_i==1.
//  frame_err_cnt_o saturates at all-ones; clr_i has priority over same-cycle increment/set.
//  Async rstn mid-frame: immediate return to reset values; partial frame lost.
//  cmd_idx_o/arg_o/crc_o/crc_err_o only meaningful while cmd_vld_o==1; hold last values otherwise.
// CONFIGURATION
//  SD_CRC7_CHECK_EN defined: CRC7 (poly x^7+x^3+1, init 0) computed byte-serially over first 5 bytes during
//   COLLECT; crc_err_o = (computed != received) registered with cmd_vld_o; frame still presented so handler
//   can answer R1 with CRC-error bit.
//  Not defined: no CRC logic instantiated; crc_err_o tied 0.
// STRUCTURE
//  Package sd_spi_pkg: FSM enum {IDLE,COLLECT,HOLD}; START_MASK/START_VAL (2'b01), CRC7_POLY 7'h09,
//   SD_FRAME_BYTES=6, function crc7_byte(crc,byte) (one-byte step, shared with future response/data blocks).
//  No sub-module; CRC is the package function, FSM+datapath in this file.
// TESTING
//  1 Bytes FF FF 40 00 00 00 00 95, rdy=1 -> one cmd_vld pulse, idx=0, arg=0, crc=7'h4A, crc_err=0.
//  2 Bytes 48 00 00 01 AA 87 -> idx=8, arg=32'h000001AA, crc=7'h43, crc_err=0.
//  3 Bytes 40 00 00 00 00 97 -> cmd_vld, crc=7'h4B; crc_err=1 with SD_CRC7_CHECK_EN, 0 without.
//  4 Bytes 40 00 00 00 00 94 (end bit 0) -> no cmd_vld, frame_err_cnt=1; next valid CMD0 decoded normally.
//  5 Send 40 00 00, raise nss 1 cycle, lower, send 77 00 00 00 00 65 -> only idx=55 frame reported.
//  6 rdy=0 after CMD0, send 2 more bytes -> fields stable, ovr_o=1; rdy=1 -> vld drops; clr_i -> ovr_o=0.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// ============================================================================
// Module  : sd_spi_pkg
// Purpose : Shared types and constants for the SD-card SPI-mode blocks.
//           Provides the command-framer FSM states, start-byte match values,
//           frame length, and a byte-serial CRC7 step that the response and
//           data blocks will reuse.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sd_spi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  // Start byte is 01xx_xxxx: start bit 0 followed by transmission bit 1.
  localparam logic [1:0] START_MASK = 2'b11;
  localparam logic [1:0] START_VAL  = 2'b01;

  // x^7 + x^3 + 1 with the implicit x^7 term dropped.
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int SD_FRAME_BYTES = 6;

  // One byte of CRC7, MSB first (the order bits appear on the wire).
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) begin
        c = c ^ CRC7_POLY;
      end
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sd_spi_cmd_framer.sv
// ============================================================================
// Module  : sd_spi_cmd_framer
// Purpose : SD-card SPI-mode command framer. Hunts the received byte stream
//           for a start byte, collects a 48-bit command frame, checks the end
//           bit, and presents index/argument/CRC to the command handler via a
//           valid/ready handshake.
// Config  : SD_CRC7_CHECK_EN - when defined, CRC7 is computed over the first
//           five bytes and crc_err_o flags a mismatch. When undefined, no CRC
//           logic is built and crc_err_o is tied 0.
// Ports   : SCLK            in  SPI clock, state updates on posedge
//           rstn            in  asynchronous active-low reset
//           nss_i           in  chip select, high aborts any frame in progress
//           rx_byte_i[7:0]  in  received byte, MSB first on the wire
//           rx_vld_i        in  one-cycle strobe, rx_byte_i valid
//           cmd_rdy_i       in  handler accepts the current command
//           clr_i           in  clears ovr_o and frame_err_cnt_o
//           cmd_vld_o       out command frame available
//           cmd_idx_o[5:0]  out frame bits [45:40]
//           cmd_arg_o[31:0] out frame bits [39:8]
//           cmd_crc_o[6:0]  out frame bits [7:1] as received
//           crc_err_o       out received CRC7 differs from computed CRC7
//           busy_o          out FSM not idle
//           ovr_o           out sticky, byte arrived while a command was held
//           frame_err_cnt_o out saturating count of frames with end bit 0
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_spi_cmd_framer
  import sd_spi_pkg::*;
#(
  parameter int         ERR_CNT_W = 8,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic                 SCLK,
  input  logic                 rstn,
  input  logic                 nss_i,
  input  logic [7:0]           rx_byte_i,
  input  logic                 rx_vld_i,
  input  logic                 cmd_rdy_i,
  input  logic                 clr_i,
  output logic                 cmd_vld_o,
  output logic [5:0]           cmd_idx_o,
  output logic [31:0]          cmd_arg_o,
  output logic [6:0]           cmd_crc_o,
  output logic                 crc_err_o,
  output logic                 busy_o,
  output logic                 ovr_o,
  output logic [ERR_CNT_W-1:0] frame_err_cnt_o
);

  localparam logic [2:0] LAST_BYTE = 3'(SD_FRAME_BYTES - 1);

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  // Only the low 38 bits of the first five bytes are ever needed (the two
  // framing bits of the start byte were already checked), so the shift
  // register keeps just those.
  logic [37:0]          frame_q, frame_d;
  logic                 cmd_vld_q, cmd_vld_d;
  logic [5:0]           cmd_idx_q, cmd_idx_d;
  logic [31:0]          cmd_arg_q, cmd_arg_d;
  logic [6:0]           cmd_crc_q, cmd_crc_d;
  logic                 ovr_q, ovr_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 ovr_set;
  logic                 err_inc;
  logic                 is_start;
`ifdef SD_CRC7_CHECK_EN
  logic [6:0]           crc_q, crc_d;
  logic                 crc_err_q, crc_err_d;
`endif

  assign is_start = (rx_byte_i != FILL_BYTE) &&
                    ((rx_byte_i[7:6] & START_MASK) == START_VAL);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    cmd_vld_d = cmd_vld_q;
    cmd_idx_d = cmd_idx_q;
    cmd_arg_d = cmd_arg_q;
    cmd_crc_d = cmd_crc_q;
    ovr_d     = ovr_q;
    err_cnt_d = err_cnt_q;
    ovr_set   = 1'b0;
    err_inc   = 1'b0;
`ifdef SD_CRC7_CHECK_EN
    crc_d     = crc_q;
    crc_err_d = crc_err_q;
`endif

    if (nss_i) begin
      // Deselect drops any partial or pending command; incoming bytes ignored.
      state_d   = IDLE;
      cnt_d     = 3'd0;
      cmd_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rx_vld_i && is_start) begin
            frame_d = {frame_q[29:0], rx_byte_i};
            cnt_d   = 3'd1;
            state_d = COLLECT;
`ifdef SD_CRC7_CHECK_EN
            crc_d   = crc7_byte(7'd0, rx_byte_i);
`endif
          end
        end

        COLLECT: begin
          if (rx_vld_i) begin
            if (cnt_q == LAST_BYTE) begin
              cnt_d = 3'd0;
              if (rx_byte_i[0]) begin
                state_d   = HOLD;
                cmd_vld_d = 1'b1;
                cmd_idx_d = frame_q[37:32];
                cmd_arg_d = frame_q[31:0];
                cmd_crc_d = rx_byte_i[7:1];
`ifdef SD_CRC7_CHECK_EN
                crc_err_d = (crc_q != rx_byte_i[7:1]);
`endif
              end else begin
                state_d = IDLE;
                err_inc = 1'b1;
              end
            end else begin
              frame_d = {frame_q[29:0], rx_byte_i};
              cnt_d   = cnt_q + 3'd1;
`ifdef SD_CRC7_CHECK_EN
              crc_d   = crc7_byte(crc_q, rx_byte_i);
`endif
            end
          end
        end

        HOLD: begin
          // The handler has not consumed the command, so any byte is lost.
          if (rx_vld_i) begin
            ovr_set = 1'b1;
          end
          if (cmd_vld_q && cmd_rdy_i) begin
            cmd_vld_d = 1'b0;
            state_d   = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Clear wins over a same-cycle set or increment.
    if (clr_i) begin
      ovr_d     = 1'b0;
      err_cnt_d = '0;
    end else begin
      if (ovr_set) begin
        ovr_d = 1'b1;
      end
      if (err_inc && !(&err_cnt_q)) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge SCLK or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      frame_q   <= '0;
      cmd_vld_q <= 1'b0;
      cmd_idx_q <= '0;
      cmd_arg_q <= '0;
      cmd_crc_q <= '0;
      ovr_q     <= 1'b0;
      err_cnt_q <= '0;
`ifdef SD_CRC7_CHECK_EN
      crc_q     <= '0;
      crc_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      cmd_vld_q <= cmd_vld_d;
      cmd_idx_q <= cmd_idx_d;
      cmd_arg_q <= cmd_arg_d;
      cmd_crc_q <= cmd_crc_d;
      ovr_q     <= ovr_d;
      err_cnt_q <= err_cnt_d;
`ifdef SD_CRC7_CHECK_EN
      crc_q     <= crc_d;
      crc_err_q <= crc_err_d;
`endif
    end
  end

  assign cmd_vld_o       = cmd_vld_q;
  assign cmd_idx_o       = cmd_idx_q;
  assign cmd_arg_o       = cmd_arg_q;
  assign cmd_crc_o       = cmd_crc_q;
  assign busy_o          = (state_q != IDLE);
  assign ovr_o           = ovr_q;
  assign frame_err_cnt_o = err_cnt_q;
`ifdef SD_CRC7_CHECK_EN
  assign crc_err_o       = crc_err_q;
`else
  assign crc_err_o       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sd_spi_cmd_framer.sv
// ============================================================================
// Module  : tb_sd_spi_cmd_framer
// Purpose : Self-checking bench for sd_spi_cmd_framer. Directed SD command
//           scenarios followed by randomized byte streams, all checked each
//           cycle against a frame-level reference model. Honours
//           SD_CRC7_CHECK_EN for the expected crc_err_o.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sd_spi_cmd_framer;

  logic        SCLK = 1'b0;
  logic        rstn = 1'b0;
  logic        nss_i = 1'b0;
  logic [7:0]  rx_byte_i = 8'h00;
  logic        rx_vld_i = 1'b0;
  logic        cmd_rdy_i = 1'b0;
  logic        clr_i = 1'b0;
  logic        cmd_vld_o;
  logic [5:0]  cmd_idx_o;
  logic [31:0] cmd_arg_o;
  logic [6:0]  cmd_crc_o;
  logic        crc_err_o;
  logic        busy_o;
  logic        ovr_o;
  logic [7:0]  frame_err_cnt_o;

  always #5 SCLK = ~SCLK;

  sd_spi_cmd_framer #(.ERR_CNT_W(8), .FILL_BYTE(8'hFF)) dut (
    .SCLK            (SCLK),
    .rstn            (rstn),
    .nss_i           (nss_i),
    .rx_byte_i       (rx_byte_i),
    .rx_vld_i        (rx_vld_i),
    .cmd_rdy_i       (cmd_rdy_i),
    .clr_i           (clr_i),
    .cmd_vld_o       (cmd_vld_o),
    .cmd_idx_o       (cmd_idx_o),
    .cmd_arg_o       (cmd_arg_o),
    .cmd_crc_o       (cmd_crc_o),
    .crc_err_o       (crc_err_o),
    .busy_o          (busy_o),
    .ovr_o           (ovr_o),
    .frame_err_cnt_o (frame_err_cnt_o)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int vld_pulses = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic [7:0]  m_q[$];
  logic        m_vld;
  logic [5:0]  m_idx;
  logic [31:0] m_arg;
  logic [6:0]  m_crc;
  logic        m_cerr;
  logic        m_ovr;
  logic [7:0]  m_err;

  // CRC7 as polynomial long division of msg * x^7 by x^7 + x^3 + 1.
  function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_vld = 0; m_idx = 0; m_arg = 0; m_crc = 0; m_cerr = 0; m_ovr = 0; m_err = 0;
  endtask

  task automatic model_step(input logic [7:0] b, input logic v, input logic rdy,
                            input logic nss, input logic clr);
    logic        set_ovr;
    logic        bad_end;
    logic [39:0] msg;
    set_ovr = 0;
    bad_end = 0;
    if (nss) begin
      m_q.delete();
      m_vld = 0;
    end else if (m_vld) begin
      if (v) set_ovr = 1;
      if (rdy) m_vld = 0;
    end else if (v) begin
      if (m_q.size() == 0) begin
        if (b[7:6] == 2'b01) m_q.push_back(b);
      end else begin
        m_q.push_back(b);
        if (m_q.size() == 6) begin
          if (b[0]) begin
            msg    = {m_q[0], m_q[1], m_q[2], m_q[3], m_q[4]};
            m_vld  = 1;
            m_idx  = m_q[0][5:0];
            m_arg  = msg[31:0];
            m_crc  = b[7:1];
`ifdef SD_CRC7_CHECK_EN
            m_cerr = (ref_crc7(msg) != b[7:1]);
`else
            m_cerr = 0;
`endif
          end else begin
            bad_end = 1;
          end
          m_q.delete();
        end
      end
    end
    if (clr) begin
      m_ovr = 0;
      m_err = 0;
    end else begin
      if (set_ovr) m_ovr = 1;
      if (bad_end && m_err != 8'hFF) m_err = m_err + 8'd1;
    end
  endtask

  task automatic check_all();
    chk("vld",     64'(cmd_vld_o),       64'(m_vld));
    chk("busy",    64'(busy_o),          64'(m_vld || (m_q.size() != 0)));
    chk("ovr",     64'(ovr_o),           64'(m_ovr));
    chk("err_cnt", 64'(frame_err_cnt_o), 64'(m_err));
    chk("idx",     64'(cmd_idx_o),       64'(m_idx));
    chk("arg",     64'(cmd_arg_o),       64'(m_arg));
    chk("crc",     64'(cmd_crc_o),       64'(m_crc));
    chk("crc_err", 64'(crc_err_o),       64'(m_cerr));
  endtask

  // One SCLK cycle: inputs driven after the falling edge, checked at the next.
  task automatic cyc(input logic [7:0] b, input logic v, input logic rdy,
                     input logic nss, input logic clr);
    rx_byte_i = b; rx_vld_i = v; cmd_rdy_i = rdy; nss_i = nss; clr_i = clr;
    @(posedge SCLK);
    model_step(b, v, rdy, nss, clr);
    @(negedge SCLK);
    check_all();
    if (cmd_vld_o && !m_vld_prev) vld_pulses++;
    m_vld_prev = cmd_vld_o;
  endtask
  logic m_vld_prev = 1'b0;

  task automatic send(input logic [7:0] b, input logic rdy);
    cyc(b, 1'b1, rdy, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  // Randomized cycle: occasional deselect, clear and back-pressure.
  task automatic rcyc(input logic [7:0] b, input logic v);
    cyc(b, v, ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0),
        ($urandom_range(0, 79) == 0));
  endtask

  logic [7:0] fb[6];
  logic [7:0] seq8[8];
  logic [39:0] msg;
  logic [5:0]  ridx;
  logic [31:0] rarg;
  logic [6:0]  rcrc;

  initial begin
    model_reset();
    #2;
    check_all();
    @(negedge SCLK);
    rstn = 1'b1;
    idle(2, 1'b1);

    // CMD0 behind fill bytes, handler always ready.
    vld_pulses = 0;
    seq8 = '{8'hFF, 8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
    for (int i = 0; i < 8; i++) send(seq8[i], 1'b1);
    chk("t1_idx", 64'(cmd_idx_o), 64'd0);
    chk("t1_crc", 64'(cmd_crc_o), 64'h4A);
    chk("t1_cerr", 64'(crc_err_o), 64'd0);
    idle(3, 1'b1);
    chk("t1_pulses", 64'(vld_pulses), 64'd1);

    // CMD8 with the standard check pattern.
    fb = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87};
    for (int i = 0; i < 6; i++) send(fb[i], 1'b0);
    chk("t2_idx", 64'(cmd_idx_o), 64'd8);
    chk("t2_arg", 64'(cmd_arg_o), 64'h1AA);
    chk("t2_crc", 64'(cmd_crc_o), 64'h43);
    chk("t2_cerr", 64'(crc_err_o), 64'd0);
    idle(1, 1'b1);

    // CMD0 with a corrupted CRC is still presented.
    fb = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h97};
    for (int i = 0; i < 6; i++) send(fb[i], 1'b0);
    chk("t3_vld", 64'(cmd_vld_o), 64'd1);
    chk("t3_crc", 64'(cmd_crc_o), 64'h4B);
`ifdef SD_CRC7_CHECK_EN
    chk("t3_cerr", 64'(crc_err_o), 64'd1);
`else
    chk("t3_cerr", 64'(crc_err_o), 64'd0);
`endif
    idle(1, 1'b1);

    // End bit 0 drops the frame; the next CMD0 decodes normally.
    fb = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h94};
    for (int i = 0; i < 6; i++) send(fb[i], 1'b1);
    chk("t4_vld", 64'(cmd_vld_o), 64'd0);
    chk("t4_err", 64'(frame_err_cnt_o), 64'd1);
    fb = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
    for (int i = 0; i < 6; i++) send(fb[i], 1'b0);
    chk("t4_vld2", 64'(cmd_vld_o), 64'd1);
    idle(1, 1'b1);

    // Deselect mid-frame, then CMD55.
    send(8'h40, 1'b1); send(8'h00, 1'b1); send(8'h00, 1'b1);
    cyc(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    fb = '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h65};
    for (int i = 0; i < 6; i++) send(fb[i], 1'b0);
    chk("t5_idx", 64'(cmd_idx_o), 64'd55);
    chk("t5_cerr", 64'(crc_err_o), 64'd0);
    idle(1, 1'b1);

    // Overrun while holding, release, clear.
    fb = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
    for (int i = 0; i < 6; i++) send(fb[i], 1'b0);
    send(8'h51, 1'b0); send(8'h12, 1'b0);
    chk("t6_ovr", 64'(ovr_o), 64'd1);
    chk("t6_idx", 64'(cmd_idx_o), 64'd0);
    idle(1, 1'b1);
    chk("t6_vld", 64'(cmd_vld_o), 64'd0);
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t6_clr", 64'(ovr_o), 64'd0);

    // Asynchronous reset in the middle of a frame.
    send(8'h41, 1'b1); send(8'h22, 1'b1);
    #2 rstn = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge SCLK);
    rstn = 1'b1;
    idle(1, 1'b1);

    // Error counter saturation, then clear beating a same-cycle increment.
    fb = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h94};
    for (int k = 0; k < 258; k++)
      for (int i = 0; i < 6; i++) send(fb[i], 1'b1);
    chk("sat", 64'(frame_err_cnt_o), 64'hFF);
    for (int i = 0; i < 5; i++) send(fb[i], 1'b1);
    cyc(fb[5], 1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr_prio", 64'(frame_err_cnt_o), 64'd0);

    // Randomized streams of frames, junk and gaps.
    for (int n = 0; n < 300; n++) begin
      ridx = 6'($urandom);
      rarg = $urandom;
      msg  = {2'b01, ridx, rarg};
      rcrc = ref_crc7(msg);
      if ($urandom_range(0, 4) == 0) rcrc = 7'($urandom);
      fb[0] = msg[39:32]; fb[1] = msg[31:24]; fb[2] = msg[23:16];
      fb[3] = msg[15:8];  fb[4] = msg[7:0];
      fb[5] = {rcrc, ($urandom_range(0, 5) != 0)};
      for (int g = $urandom_range(0, 2); g > 0; g--)
        rcyc(($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom), 1'b1);
      for (int i = 0; i < 6; i++) begin
        rcyc(fb[i], 1'b1);
        if ($urandom_range(0, 3) == 0) rcyc(8'($urandom), 1'b0);
      end
      for (int g = $urandom_range(0, 3); g > 0; g--) rcyc(8'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
